// File: rtl/instruction_decoder.sv
// -----------------------------------------------------------------------------
// InstructionDecoder
//
// Purpose:
//    Single-slot decode stage between instruction fetch and the next pipeline
//    stage. A fetched word is captured with a one-cycle acknowledge, decoded
//    into an operation class, register fields and an extended immediate, and
//    then held valid until the next stage consumes it. The block also keeps
//    statistics counters for decoded and illegal instructions.
//
// Ports:
//    clk            - system clock, all state changes on the rising edge
//    reset          - synchronous, active-high reset
//    DIR            - fetch stage has an instruction word ready
//    data_in        - fetched 32-bit instruction word, valid while DIR=1
//    ack_prev       - one-cycle capture acknowledge back to the fetch stage
//    DOR            - decoded fields are valid for the next stage
//    ack_from_next  - next stage has consumed the decoded fields
//    op_class       - 0 NOP, 1 ALU-reg, 2 ALU-imm, 3 LOAD, 4 STORE,
//                     5 BRANCH, 6 JUMP, 7 ILLEGAL
//    rd/rs1/rs2     - raw register fields [25:21], [20:16], [15:11]
//    imm            - extended immediate
//    illegal        - opcode is undefined
//    decoded_count  - wrapping count of decoded instructions
//    illegal_count  - saturating count of illegal instructions
// -----------------------------------------------------------------------------
module instruction_decoder #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   DIR,
    input  logic [31:0]            data_in,
    output logic                   ack_prev,
    output logic                   DOR,
    input  logic                   ack_from_next,
    output logic [2:0]             op_class,
    output logic [4:0]             rd,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [31:0]            imm,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] decoded_count,
    output logic [7:0]             illegal_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DECODE    = 2'd1,
        WAIT_NEXT = 2'd2
    } stateT;

    localparam logic [2:0] CLASS_NOP     = 3'd0;
    localparam logic [2:0] CLASS_ALU_REG = 3'd1;
    localparam logic [2:0] CLASS_ALU_IMM = 3'd2;
    localparam logic [2:0] CLASS_LOAD    = 3'd3;
    localparam logic [2:0] CLASS_STORE   = 3'd4;
    localparam logic [2:0] CLASS_BRANCH  = 3'd5;
    localparam logic [2:0] CLASS_JUMP    = 3'd6;
    localparam logic [2:0] CLASS_ILLEGAL = 3'd7;

    stateT                  state_q;
    logic [31:0]            wordReg_q;
    logic                   ackPrev_q;
    logic                   dor_q;
    logic [2:0]             opClass_q;
    logic [4:0]             rd_q;
    logic [4:0]             rs1_q;
    logic [4:0]             rs2_q;
    logic [31:0]            imm_q;
    logic                   illegal_q;
    logic [COUNT_WIDTH-1:0] decodedCount_q;
    logic [7:0]             illegalCount_q;

    logic [5:0]             opcode;
    logic [31:0]            immSext;
    logic [2:0]             opClass_d;
    logic [31:0]            imm_d;
    logic                   illegal_d;

    // Combinational decode of the latched word; results are only registered
    // into the outputs while in DECODE, so the outputs stay frozen otherwise.
    assign opcode  = wordReg_q[31:26];
    assign immSext = {{16{wordReg_q[15]}}, wordReg_q[15:0]};

    always_comb begin
        opClass_d = CLASS_ILLEGAL;
        imm_d     = 32'd0;
        illegal_d = 1'b0;
        if (opcode == 6'h00) begin
            opClass_d = CLASS_NOP;
        end else if (opcode <= 6'h0F) begin
            opClass_d = CLASS_ALU_REG;
        end else if (opcode <= 6'h17) begin
            opClass_d = CLASS_ALU_IMM;
            imm_d     = immSext;
        end else if (opcode == 6'h18) begin
            opClass_d = CLASS_LOAD;
            imm_d     = immSext;
        end else if (opcode == 6'h19) begin
            opClass_d = CLASS_STORE;
            imm_d     = immSext;
        end else if (opcode <= 6'h1D) begin
            opClass_d = CLASS_BRANCH;
            imm_d     = immSext;
        end else if (opcode == 6'h1E) begin
            opClass_d = CLASS_JUMP;
            imm_d     = {6'b0, wordReg_q[25:0]};
        end else begin
            opClass_d = CLASS_ILLEGAL;
            illegal_d = 1'b1;
        end
    end

    // Handshake FSM with registered outputs. DIR is only looked at in IDLE,
    // so a request arriving while a word is in flight waits until the FSM has
    // spent at least one cycle back in IDLE (one-deep backpressure). DOR goes
    // high on the edge that leaves DECODE, so the next stage first samples it
    // two edges after the capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            wordReg_q      <= 32'd0;
            ackPrev_q      <= 1'b0;
            dor_q          <= 1'b0;
            opClass_q      <= 3'd0;
            rd_q           <= 5'd0;
            rs1_q          <= 5'd0;
            rs2_q          <= 5'd0;
            imm_q          <= 32'd0;
            illegal_q      <= 1'b0;
            decodedCount_q <= '0;
            illegalCount_q <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    dor_q <= 1'b0;
                    if (DIR) begin
                        wordReg_q <= data_in;
                        ackPrev_q <= 1'b1;
                        state_q   <= DECODE;
                    end else begin
                        ackPrev_q <= 1'b0;
                    end
                end
                DECODE: begin
                    ackPrev_q      <= 1'b0;
                    dor_q          <= 1'b1;
                    opClass_q      <= opClass_d;
                    rd_q           <= wordReg_q[25:21];
                    rs1_q          <= wordReg_q[20:16];
                    rs2_q          <= wordReg_q[15:11];
                    imm_q          <= imm_d;
                    illegal_q      <= illegal_d;
                    decodedCount_q <= decodedCount_q + COUNT_WIDTH'(1);
                    if (illegal_d && (illegalCount_q != 8'hFF)) begin
                        illegalCount_q <= illegalCount_q + 8'd1;
                    end
                    state_q        <= WAIT_NEXT;
                end
                WAIT_NEXT: begin
                    ackPrev_q <= 1'b0;
                    if (ack_from_next) begin
                        dor_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ackPrev_q <= 1'b0;
                    dor_q     <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign ack_prev      = ackPrev_q;
    assign DOR           = dor_q;
    assign op_class      = opClass_q;
    assign rd            = rd_q;
    assign rs1           = rs1_q;
    assign rs2           = rs2_q;
    assign imm           = imm_q;
    assign illegal       = illegal_q;
    assign decoded_count = decodedCount_q;
    assign illegal_count = illegalCount_q;

endmodule
